// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (fetch/data) arbiter onto a single-outstanding memory bus.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_read,
   output logic              bus_write,
   input  logic              bus_busy,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_q,   state_d;
   logic [1:0]        streak_q,  streak_d;
   logic              win_d_q,   win_d_d;   // 1 = data port owns the current transaction
   logic              we_q,      we_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [DATA_W-1:0] wdata_q,   wdata_d;
   logic [DATA_W-1:0] irdata_q,  irdata_d;
   logic [DATA_W-1:0] drdata_q,  drdata_d;
   logic              grant_data;

   // Data has priority, but two consecutive data wins under fetch contention yield one slot.
   assign grant_data = d_req && !(streak_q == 2'd2 && i_req);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         streak_q <= 2'd0;
         win_d_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         irdata_q <= '0;
         drdata_q <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         win_d_q  <= win_d_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      win_d_d  = win_d_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      case (state_q)
         IDLE: begin
            if (!bus_busy && (i_req || d_req)) begin
               state_d = ISSUE;
               win_d_d = grant_data;
               if (grant_data) begin
                  addr_d = d_addr;
                  we_d   = d_we;
                  if (d_we) begin
                     wdata_d = d_wdata;
                  end
                  if (i_req && streak_q != 2'd2) begin
                     streak_d = streak_q + 2'd1;
                  end
               end else begin
                  addr_d   = i_addr;
                  we_d     = 1'b0;
                  streak_d = 2'd0;
               end
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (!bus_busy) begin
               state_d = DONE;
               if (!we_q) begin
                  if (win_d_q) begin
                     drdata_d = bus_rdata;
                  end else begin
                     irdata_d = bus_rdata;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign state     = state_q;
   assign bus_read  = (state_q == ISSUE) && !we_q;
   assign bus_write = (state_q == ISSUE) &&  we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign i_ack     = (state_q == DONE) && !win_d_q;
   assign d_ack     = (state_q == DONE) &&  win_d_q;
   assign i_rdata   = irdata_q;
   assign d_rdata   = drdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed scenarios plus a randomized run against a transaction timeline model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we, bus_busy;
   logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
   logic        i_ack, d_ack, bus_read, bus_write;
   logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Bus responder controls
   int          stall   = 0;
   int          ext_pct = 0;
   int          phase   = 0;
   int          bcnt    = 0;
   logic        bus_hold = 1'b0;
   logic [31:0] rd_val  = 32'h0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_read(bus_read),
      .bus_write(bus_write), .bus_busy(bus_busy), .bus_rdata(bus_rdata),
      .state(state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      checks++;
      if ((i_ack & d_ack) !== 1'b0) begin
         errors++;
         $display("FAIL ack_mutex: i_ack=%b d_ack=%b, required not both 1", i_ack, d_ack);
      end
      checks++;
      if ((bus_read & bus_write) !== 1'b0) begin
         errors++;
         $display("FAIL strobe_mutex: bus_read=%b bus_write=%b, required not both 1", bus_read, bus_write);
      end
   end

   // One cycle: advance past the edge, then act as the bus for the new cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus_read || bus_write) begin
         phase     = 1;
         bcnt      = stall;
         bus_busy  = 1'b0;
         bus_rdata = rd_val;
      end else if (phase == 1) begin
         if (bcnt > 0) begin
            bus_busy = 1'b1;
            bcnt--;
         end else begin
            bus_busy = 1'b0;
            phase    = 2;
         end
      end else begin
         phase     = 0;
         bus_busy  = bus_hold || ($urandom_range(0, 99) < ext_pct);
         bus_rdata = $urandom;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({state, i_ack, d_ack, bus_read, bus_write} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: state=%0d i_ack=%b d_ack=%b rd=%b wr=%b, required all 0",
                  state, i_ack, d_ack, bus_read, bus_write);
      end
      checks++;
      if (i_rdata !== 32'h0 || d_rdata !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: i_rdata=%h d_rdata=%h bus_addr=%h bus_wdata=%h, required 0",
                  i_rdata, d_rdata, bus_addr, bus_wdata);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (state !== 2'd0 || bus_read !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: state=%0d bus_read=%b, required 0 0", state, bus_read);
      end
   endtask

   task automatic test_data_read();
      stall = 0; rd_val = 32'hDEADBEEF;
      d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
      tick();
      checks++;
      if (bus_read !== 1'b1 || bus_write !== 1'b0 || bus_addr !== 32'h40 || state !== 2'd1) begin
         errors++;
         $display("FAIL rd_issue: rd=%b wr=%b addr=%h state=%0d, required 1 0 00000040 1",
                  bus_read, bus_write, bus_addr, state);
      end
      tick();
      checks++;
      if ({bus_read, bus_write, d_ack} !== 3'b000 || state !== 2'd2) begin
         errors++;
         $display("FAIL rd_wait: rd=%b wr=%b d_ack=%b state=%0d, required 0 0 0 2",
                  bus_read, bus_write, d_ack, state);
      end
      tick();
      checks++;
      if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_done: d_ack=%b i_ack=%b d_rdata=%h, required 1 0 deadbeef", d_ack, i_ack, d_rdata);
      end
      d_req = 1'b0;
      tick();
      checks++;
      if (d_ack !== 1'b0 || state !== 2'd0 || d_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_after: d_ack=%b state=%0d d_rdata=%h, required 0 0 deadbeef", d_ack, state, d_rdata);
      end
   endtask

   task automatic test_write_stall();
      int nw, nr, iss, ackc;
      nw = 0; nr = 0; iss = -1; ackc = -1;
      stall = 4;
      d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234; d_req = 1'b1;
      for (int k = 0; k < 20 && ackc < 0; k++) begin
         tick();
         if (bus_write) begin
            nw++;
            if (iss < 0) iss = cyc;
         end
         if (bus_read) nr++;
         if (d_ack) begin
            ackc  = cyc;
            d_req = 1'b0;
            checks++;
            if (bus_addr !== 32'h44 || bus_wdata !== 32'h1234) begin
               errors++;
               $display("FAIL wr_stable: addr=%h wdata=%h, required 00000044 00001234", bus_addr, bus_wdata);
            end
         end
      end
      checks++;
      if (nw != 1 || nr != 0) begin
         errors++;
         $display("FAIL wr_strobes: writes=%0d reads=%0d, required 1 0", nw, nr);
      end
      checks++;
      if (ackc < 0 || ackc != iss + 6) begin
         errors++;
         $display("FAIL wr_latency: ack_cycle=%0d, required %0d", ackc, iss + 6);
      end
      checks++;
      if (d_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_rdata_hold: d_rdata=%h, required deadbeef", d_rdata);
      end
      stall = 0;
      tick();
   endtask

   task automatic test_conflict();
      logic [5:0] seq;
      int n;
      seq = 6'b0; n = 0;
      stall = 0;
      i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 200 && n < 6; k++) begin
         tick();
         if (bus_read || bus_write) begin
            seq[n] = (bus_addr == 32'h200);
            n++;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      checks++;
      if (n != 6 || seq !== 6'b011011) begin
         errors++;
         $display("FAIL conflict_order: grants=%0d order(bit0 first,1=D)=%b, required 6 011011", n, seq);
      end
      repeat (4) tick();
   endtask

   task automatic test_blocked_bus();
      int nstb, nbad;
      logic got;
      nstb = 0; nbad = 0; got = 1'b0;
      bus_hold = 1'b1;
      tick();
      stall = 0; rd_val = 32'h55AA1234;
      i_addr = 32'h300; i_req = 1'b1;
      repeat (5) begin
         tick();
         if (bus_read || bus_write) nstb++;
         if (state !== 2'd0) nbad++;
      end
      checks++;
      if (nstb != 0 || nbad != 0) begin
         errors++;
         $display("FAIL blocked_idle: strobes=%0d non_idle_cycles=%0d, required 0 0", nstb, nbad);
      end
      bus_hold = 1'b0; bus_busy = 1'b0;
      tick();
      checks++;
      if (bus_read !== 1'b1 || bus_addr !== 32'h300 || state !== 2'd1) begin
         errors++;
         $display("FAIL blocked_grant: rd=%b addr=%h state=%0d, required 1 00000300 1", bus_read, bus_addr, state);
      end
      for (int k = 0; k < 10 && !got; k++) begin
         tick();
         if (i_ack) begin
            got   = 1'b1;
            i_req = 1'b0;
            checks++;
            if (i_rdata !== 32'h55AA1234) begin
               errors++;
               $display("FAIL blocked_rdata: i_rdata=%h, required 55aa1234", i_rdata);
            end
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL blocked_ack: i_ack=0 after 10 cycles, required 1");
         i_req = 1'b0;
      end
      tick();
   endtask

   task automatic test_reset_in_wait();
      logic reached;
      int nack, nstb;
      reached = 1'b0; nack = 0; nstb = 0;
      stall = 6; rd_val = 32'h11112222;
      d_we = 1'b0; d_addr = 32'h48; d_req = 1'b1;
      for (int k = 0; k < 10 && !reached; k++) begin
         tick();
         if (state === 2'd2) reached = 1'b1;
      end
      checks++;
      if (!reached) begin
         errors++;
         $display("FAIL rstwait_reach: state=%0d, required 2", state);
      end
      tick();
      rst = 1'b1; d_req = 1'b0;
      tick();
      tick();
      checks++;
      if ({state, i_ack, d_ack, bus_read, bus_write} !== 6'b0 ||
          i_rdata !== 32'h0 || d_rdata !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
         errors++;
         $display("FAIL rstwait_outputs: state=%0d acks=%b%b strobes=%b%b i_rd=%h d_rd=%h addr=%h wd=%h, required all 0",
                  state, i_ack, d_ack, bus_read, bus_write, i_rdata, d_rdata, bus_addr, bus_wdata);
      end
      rst = 1'b0; phase = 0; bcnt = 0; bus_busy = 1'b0;
      repeat (6) begin
         tick();
         if (i_ack || d_ack) nack++;
         if (bus_read || bus_write) nstb++;
      end
      checks++;
      if (nack != 0 || nstb != 0) begin
         errors++;
         $display("FAIL rstwait_abandon: acks=%0d strobes=%0d, required 0 0", nack, nstb);
      end
      stall = 0; rd_val = 32'hCAFEF00D;
      i_addr = 32'h80; i_req = 1'b1;
      tick();
      checks++;
      if (bus_read !== 1'b1 || bus_addr !== 32'h80) begin
         errors++;
         $display("FAIL rstwait_fetch_issue: rd=%b addr=%h, required 1 00000080", bus_read, bus_addr);
      end
      tick();
      tick();
      checks++;
      if (i_ack !== 1'b1 || i_rdata !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL rstwait_fetch_done: i_ack=%b i_rdata=%h, required 1 cafef00d", i_ack, i_rdata);
      end
      i_req = 1'b0;
      tick();
   endtask

   // Model: a transaction granted at the edge ending cycle g strobes in g+1 and acks in g+stall+3.
   task automatic test_random();
      int          pst_i, pst_d, streak, free_c, exp_s, exp_a;
      logic        exp_win, exp_we;
      logic [1:0]  exp_state;
      logic [31:0] exp_addr, exp_wdata, exp_rdv, m_ird, m_drd;
      pst_i = 0; pst_d = 0; streak = 0; free_c = cyc; exp_s = -1; exp_a = -1;
      exp_win = 1'b0; exp_we = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_rdv = 32'h0;
      m_ird = 32'hCAFEF00D; m_drd = 32'h0;
      ext_pct = 25;
      for (int n = 0; n < 2000; n++) begin
         tick();
         if (cyc == exp_a && !exp_we) begin
            if (exp_win) m_drd = exp_rdv;
            else         m_ird = exp_rdv;
         end
         exp_state = (cyc >= free_c) ? 2'd0 : (cyc == exp_s) ? 2'd1 : (cyc == exp_a) ? 2'd3 : 2'd2;
         checks++;
         if (state !== exp_state) begin
            errors++;
            $display("FAIL rnd_state: cycle %0d state=%0d, required %0d", cyc, state, exp_state);
         end
         checks++;
         if ({bus_read, bus_write} !== ((cyc == exp_s) ? {!exp_we, exp_we} : 2'b00)) begin
            errors++;
            $display("FAIL rnd_strobe: cycle %0d rd/wr=%b%b, required %b", cyc, bus_read, bus_write,
                     (cyc == exp_s) ? {!exp_we, exp_we} : 2'b00);
         end
         checks++;
         if ({i_ack, d_ack} !== ((cyc == exp_a) ? {!exp_win, exp_win} : 2'b00)) begin
            errors++;
            $display("FAIL rnd_ack: cycle %0d i/d_ack=%b%b, required %b", cyc, i_ack, d_ack,
                     (cyc == exp_a) ? {!exp_win, exp_win} : 2'b00);
         end
         checks++;
         if (i_rdata !== m_ird || d_rdata !== m_drd) begin
            errors++;
            $display("FAIL rnd_rdata: cycle %0d i_rdata=%h d_rdata=%h, required %h %h",
                     cyc, i_rdata, d_rdata, m_ird, m_drd);
         end
         if (cyc >= exp_s && cyc <= exp_a) begin
            checks++;
            if (bus_addr !== exp_addr || (exp_we && bus_wdata !== exp_wdata)) begin
               errors++;
               $display("FAIL rnd_bus: cycle %0d addr=%h wdata=%h, required %h %h",
                        cyc, bus_addr, bus_wdata, exp_addr, exp_wdata);
            end
         end
         if (cyc == exp_a) begin
            if (exp_win) pst_d = 0;
            else         pst_i = 0;
         end
         if (pst_i == 2 && $urandom_range(0, 3) == 0) i_req = 1'b0;
         if (pst_d == 2 && $urandom_range(0, 3) == 0) d_req = 1'b0;
         if (pst_i == 0) begin
            i_addr = $urandom; i_req = 1'b0;
            if ($urandom_range(0, 99) < 35) begin pst_i = 1; i_req = 1'b1; end
         end
         if (pst_d == 0) begin
            d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1)); d_req = 1'b0;
            if ($urandom_range(0, 99) < 35) begin pst_d = 1; d_req = 1'b1; end
         end
         if (cyc >= free_c && !bus_busy && (i_req || d_req)) begin
            exp_win = d_req && !(streak == 2 && i_req);
            if (exp_win) begin
               if (i_req && streak < 2) streak++;
               pst_d = 2; exp_we = d_we; exp_addr = d_addr; exp_wdata = d_wdata;
            end else begin
               streak = 0;
               pst_i = 2; exp_we = 1'b0; exp_addr = i_addr;
            end
            stall   = int'($urandom_range(0, 3));
            rd_val  = $urandom;
            exp_rdv = rd_val;
            exp_s   = cyc + 1;
            exp_a   = cyc + stall + 3;
            free_c  = exp_a + 1;
         end
      end
      ext_pct = 0; i_req = 1'b0; d_req = 1'b0;
      repeat (8) tick();
   endtask

   initial begin
      rst = 1'b1;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      bus_busy = 1'b0; bus_rdata = 32'h0;
      test_reset();
      test_data_read();
      test_write_stall();
      test_conflict();
      test_blocked_bus();
      test_reset_in_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
